// File: rtl/instr_register_v2.sv
// Instruction register file: DEPTH entries of {opcode, operand_a, operand_b},
// each with a valid bit. Registered read port with valid/error strobes,
// optional consume-on-read, occupancy counter and full/empty flags.
module instr_register_v2 #(
  parameter int DEPTH = 32,
  parameter int OPC_W = 4,
  parameter int OPD_W = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load_en,
  input  logic [AW-1:0]    write_pointer,
  input  logic [OPC_W-1:0] opcode,
  input  logic [OPD_W-1:0] operand_a,
  input  logic [OPD_W-1:0] operand_b,
  input  logic             read_en,
  input  logic             consume,
  input  logic [AW-1:0]    read_pointer,
  output logic [OPC_W-1:0] opcode_out,
  output logic [OPD_W-1:0] operand_a_out,
  output logic [OPD_W-1:0] operand_b_out,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             wr_err,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [OPC_W-1:0] opc_mem [DEPTH];
  logic [OPD_W-1:0] a_mem   [DEPTH];
  logic [OPD_W-1:0] b_mem   [DEPTH];
  logic [DEPTH-1:0] valid;

  logic wr_in_range, rd_in_range;
  logic wr_ok, wr_was_valid, rd_hit, same_addr, consumed_same;
  logic inc, dec;

  // Classify this cycle's access: legality, hits, same-address interaction
  always_comb begin
    wr_in_range   = {1'b0, write_pointer} < DEPTH_L;
    rd_in_range   = {1'b0, read_pointer} < DEPTH_L;
    wr_ok         = load_en && wr_in_range;
    wr_was_valid  = wr_in_range ? valid[write_pointer] : 1'b0;
    rd_hit        = read_en && rd_in_range && valid[read_pointer];
    same_addr     = wr_ok && read_en && rd_in_range && (write_pointer == read_pointer);
    // A consuming read of the entry being rewritten frees the slot, so the
    // write is not an overwrite; the write still wins the valid bit.
    consumed_same = same_addr && rd_hit && consume;
    inc           = wr_ok && !wr_was_valid;
    dec           = rd_hit && consume && !same_addr;
  end

  // Storage and valid bits; the write is applied after the consume so it wins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        opc_mem[i] <= '0;
        a_mem[i]   <= '0;
        b_mem[i]   <= '0;
      end
      valid <= '0;
    end else begin
      if (rd_hit && consume)
        valid[read_pointer] <= 1'b0;
      if (wr_ok) begin
        opc_mem[write_pointer] <= opcode;
        a_mem[write_pointer]   <= operand_a;
        b_mem[write_pointer]   <= operand_b;
        valid[write_pointer]   <= 1'b1;
      end
    end
  end

  // Registered read path (read-before-write) and error/valid strobes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opcode_out    <= '0;
      operand_a_out <= '0;
      operand_b_out <= '0;
      rd_valid      <= 1'b0;
      rd_err        <= 1'b0;
      wr_err        <= 1'b0;
    end else begin
      rd_valid <= rd_hit;
      rd_err   <= read_en && !rd_hit;
      wr_err   <= load_en && (!wr_in_range || (wr_was_valid && !consumed_same));
      if (rd_hit) begin
        opcode_out    <= opc_mem[read_pointer];
        operand_a_out <= a_mem[read_pointer];
        operand_b_out <= b_mem[read_pointer];
      end
    end
  end

  // Occupancy counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else
      count <= count + (AW+1)'(inc) - (AW+1)'(dec);
  end

  assign full  = (count == DEPTH_L);
  assign empty = (count == '0);

endmodule

// File: tb/tb_instr_register_v2.sv
module tb_instr_register_v2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        load_en, load_en2;
  logic [4:0]  write_pointer;
  logic [3:0]  opcode;
  logic [31:0] operand_a, operand_b;
  logic        read_en, read_en2, consume;
  logic [4:0]  read_pointer;

  logic [3:0]  opcode_out, opcode_out2;
  logic [31:0] operand_a_out, operand_b_out, operand_a_out2, operand_b_out2;
  logic        rd_valid, rd_err, wr_err, full, empty;
  logic        rd_valid2, rd_err2, wr_err2, full2, empty2;
  logic [5:0]  count, count2;

  int errors = 0;
  int checks = 0;

  instr_register_v2 #(.DEPTH(32), .OPC_W(4), .OPD_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .load_en(load_en), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_en(read_en), .consume(consume), .read_pointer(read_pointer),
    .opcode_out(opcode_out), .operand_a_out(operand_a_out), .operand_b_out(operand_b_out),
    .rd_valid(rd_valid), .rd_err(rd_err), .wr_err(wr_err),
    .count(count), .full(full), .empty(empty)
  );

  instr_register_v2 #(.DEPTH(20), .OPC_W(4), .OPD_W(32)) dut20 (
    .clk(clk), .reset_n(reset_n), .load_en(load_en2), .write_pointer(write_pointer),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_en(read_en2), .consume(consume), .read_pointer(read_pointer),
    .opcode_out(opcode_out2), .operand_a_out(operand_a_out2), .operand_b_out(operand_b_out2),
    .rd_valid(rd_valid2), .rd_err(rd_err2), .wr_err(wr_err2),
    .count(count2), .full(full2), .empty(empty2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    load_en = 0; load_en2 = 0; read_en = 0; read_en2 = 0; consume = 0;
  endtask

  task automatic wr(input int p, input int opc, input int a, input int b);
    load_en = 1; write_pointer = 5'(p); opcode = 4'(opc);
    operand_a = 32'(a); operand_b = 32'(b);
  endtask

  task automatic rd(input int p, input logic c);
    read_en = 1; read_pointer = 5'(p); consume = c;
  endtask

  function automatic int fill_a(input int i);
    return i * 3 - 50;
  endfunction

  initial begin
    reset_n = 0;
    idle();
    write_pointer = '0; read_pointer = '0; opcode = '0; operand_a = '0; operand_b = '0;
    #12;
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);
    chk("reset_full", 32'(full), 32'd0);
    chk("reset_rd_valid", 32'(rd_valid), 32'd0);
    chk("reset_opcode_out", 32'(opcode_out), 32'd0);
    chk("reset_empty20", 32'(empty2), 32'd1);
    #1 reset_n = 1;

    // Write entry 5 then read it back without consuming
    wr(5, 3, -7, 12);
    tick();
    chk("w5_count", 32'(count), 32'd1);
    chk("w5_wr_err", 32'(wr_err), 32'd0);
    chk("w5_empty", 32'(empty), 32'd0);
    idle(); rd(5, 1'b0);
    tick();
    chk("r5_opcode", 32'(opcode_out), 32'd3);
    chk("r5_a", operand_a_out, 32'hFFFF_FFF9);
    chk("r5_b", operand_b_out, 32'd12);
    chk("r5_rd_valid", 32'(rd_valid), 32'd1);
    chk("r5_rd_err", 32'(rd_err), 32'd0);
    chk("r5_count", 32'(count), 32'd1);
    idle();
    tick();
    chk("idle_rd_valid", 32'(rd_valid), 32'd0);
    chk("idle_hold_a", operand_a_out, 32'hFFFF_FFF9);

    // Fill the remaining entries
    for (int i = 0; i < 32; i++) begin
      if (i != 5) begin
        wr(i, i, fill_a(i), i + 1000);
        tick();
      end
    end
    idle();
    chk("fill_count", 32'(count), 32'd32);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_wr_err", 32'(wr_err), 32'd0);

    // Overwrite of a valid entry
    wr(0, 7, 32'h11, 32'h22);
    tick();
    chk("ovw_wr_err", 32'(wr_err), 32'd1);
    chk("ovw_count", 32'(count), 32'd32);
    idle(); rd(0, 1'b0);
    tick();
    chk("ovw_wr_err_pulse", 32'(wr_err), 32'd0);
    chk("ovw_opcode", 32'(opcode_out), 32'd7);
    chk("ovw_a", operand_a_out, 32'h11);
    chk("ovw_b", operand_b_out, 32'h22);

    // Consuming read of entry 9, then read it again
    idle(); rd(9, 1'b1);
    tick();
    chk("c9_rd_valid", 32'(rd_valid), 32'd1);
    chk("c9_opcode", 32'(opcode_out), 32'd9);
    chk("c9_a", operand_a_out, 32'hFFFF_FFE9);
    chk("c9_b", operand_b_out, 32'd1009);
    chk("c9_count", 32'(count), 32'd31);
    chk("c9_full", 32'(full), 32'd0);
    rd(9, 1'b1);
    tick();
    chk("c9b_rd_err", 32'(rd_err), 32'd1);
    chk("c9b_rd_valid", 32'(rd_valid), 32'd0);
    chk("c9b_hold_opcode", 32'(opcode_out), 32'd9);
    chk("c9b_hold_a", operand_a_out, 32'hFFFF_FFE9);
    chk("c9b_count", 32'(count), 32'd31);

    // Same-address write + consuming read
    idle(); wr(4, 2, 5, 6);
    tick();
    chk("pre4_count", 32'(count), 32'd31);
    idle(); wr(4, 1, 100, 200); rd(4, 1'b1);
    tick();
    chk("same_opcode", 32'(opcode_out), 32'd2);
    chk("same_a", operand_a_out, 32'd5);
    chk("same_b", operand_b_out, 32'd6);
    chk("same_rd_valid", 32'(rd_valid), 32'd1);
    chk("same_wr_err", 32'(wr_err), 32'd0);
    chk("same_count", 32'(count), 32'd31);
    idle(); rd(4, 1'b0);
    tick();
    chk("post4_opcode", 32'(opcode_out), 32'd1);
    chk("post4_a", operand_a_out, 32'd100);
    chk("post4_b", operand_b_out, 32'd200);
    chk("post4_rd_valid", 32'(rd_valid), 32'd1);

    // DEPTH=20 instance: out-of-range pointers and last legal entry
    idle(); load_en2 = 1; write_pointer = 5'd25; opcode = 4'd1;
    tick();
    chk("d20_wr_err", 32'(wr_err2), 32'd1);
    chk("d20_count", 32'(count2), 32'd0);
    idle(); read_en2 = 1; read_pointer = 5'd31;
    tick();
    chk("d20_rd_err", 32'(rd_err2), 32'd1);
    chk("d20_rd_valid", 32'(rd_valid2), 32'd0);
    idle(); load_en2 = 1; write_pointer = 5'd19; opcode = 4'd6; operand_a = 32'd77;
    tick();
    chk("d20_w19_wr_err", 32'(wr_err2), 32'd0);
    chk("d20_w19_count", 32'(count2), 32'd1);
    idle(); read_en2 = 1; read_pointer = 5'd19;
    tick();
    chk("d20_r19_a", operand_a_out2, 32'd77);
    chk("d20_r19_rd_valid", 32'(rd_valid2), 32'd1);

    // Asynchronous reset in the middle of a write burst
    idle();
    for (int i = 0; i < 3; i++) begin
      wr(i, 15, 32'hDEAD_0000 + i, i);
      tick();
    end
    @(posedge clk);
    #3 reset_n = 0;
    #1;
    chk("mid_rst_count", 32'(count), 32'd0);
    chk("mid_rst_empty", 32'(empty), 32'd1);
    chk("mid_rst_full", 32'(full), 32'd0);
    chk("mid_rst_wr_err", 32'(wr_err), 32'd0);
    chk("mid_rst_opcode", 32'(opcode_out), 32'd0);
    chk("mid_rst_a", operand_a_out, 32'd0);
    chk("mid_rst_count20", 32'(count2), 32'd0);
    idle();
    #2 reset_n = 1;
    for (int i = 0; i < 32; i++) begin
      rd(i, 1'b0);
      tick();
      chk($sformatf("post_rst_rd_err_%0d", i), 32'(rd_err), 32'd1);
      chk($sformatf("post_rst_rd_valid_%0d", i), 32'(rd_valid), 32'd0);
    end
    idle();
    tick();
    chk("post_rst_count", 32'(count), 32'd0);
    chk("post_rst_empty", 32'(empty), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_register_v2.md
Name: instr_register_v2

Overview:
- Parametrised instruction register file: DEPTH entries of {opcode, operand_a, operand_b}, each with a per-entry valid bit.
- Sits between the instruction-generating stimulus/controller and the execution stage.
- Adds a registered read path with a valid strobe, consume-on-read, an occupancy counter, full/empty flags and error pulses for overwrite, empty-read and out-of-range pointers.

Parameters:
- DEPTH, 32, number of entries (>=2, need not be a power of two)
- OPC_W, 4, opcode width
- OPD_W, 32, operand width (signed two's complement)
- AW, $clog2(DEPTH), pointer width (derived, not overridden)

Ports:
- clk  input  1  single clock, all logic on rising edge
- reset_n  input  1  asynchronous active-low reset
- load_en  input  1  write strobe
- write_pointer  input  AW  write entry index
- opcode  input  OPC_W  opcode to store
- operand_a  input  OPD_W  operand A to store
- operand_b  input  OPD_W  operand B to store
- read_en  input  1  read request
- consume  input  1  with read_en: invalidate the entry after reading
- read_pointer  input  AW  read entry index
- opcode_out  output  OPC_W  registered read opcode
- operand_a_out  output  OPD_W  registered read operand A
- operand_b_out  output  OPD_W  registered read operand B
- rd_valid  output  1  read data valid, 1-cycle pulse
- rd_err  output  1  read of invalid or out-of-range entry, 1-cycle pulse
- wr_err  output  1  overwrite of valid entry or out-of-range write, 1-cycle pulse
- count  output  AW+1  number of valid entries
- full  output  1  count==DEPTH
- empty  output  1  count==0

Behaviour:
- Reset (reset_n low, asynchronous, any time incl. mid-operation):
  - all entries cleared to 0 and invalid; all outputs 0 except empty=1.
  - No partial update survives; the first edge after reset release is a normal cycle.
- Write (load_en=1, write_pointer<DEPTH):
  - entry <= {opcode, operand_a, operand_b}; valid <= 1 at the edge.
  - If entry already valid and not consumed this cycle: data is still overwritten, wr_err pulses next cycle, count unchanged.
- Write with write_pointer>=DEPTH: storage unchanged, wr_err pulses.
- Read (read_en=1, read_pointer<DEPTH, entry valid):
  - outputs load the stored fields at the edge; rd_valid=1 in the following cycle only (latency 1).
  - If consume=1: valid <= 0.
- Read of an invalid entry or read_pointer>=DEPTH:
  - rd_err=1, rd_valid=0, data outputs hold their previous values; consume is ignored.
- Data outputs hold their value when no read occurs; rd_valid and rd_err are 0 in that case.
- Same-address write+read in one cycle (read-before-write):
  - read returns the old contents (or rd_err if the entry was invalid).
  - Write wins the valid bit: entry ends valid with the new data.
  - consume does not count as a removal; no wr_err.
- count update per cycle: count + inc - dec.
  - inc=1 when a legal write targets an entry invalid at the start of the cycle.
  - dec=1 when a legal consuming read hits a valid entry that is not the same-cycle write target.
  - count never exceeds DEPTH or goes below 0.
  - full and empty are combinational from count.
- Operands are stored bit-exact; no sign extension or arithmetic inside the block.

Test Plan:
- Reset with DEPTH=32: write entries 0..31, assert reset_n=0 mid-burst -> all outputs 0, empty=1, count=0; reads of 0..31 give rd_err=1.
- Write entry 5 = {opc 3, a=-7, b=12}; next cycle read 5 with consume=0 -> one cycle later opcode_out=3, operand_a_out=-7 (0xFFFFFFF9), operand_b_out=12, rd_valid=1; count stays 1.
- Fill all 32 entries -> count=32, full=1; write entry 0 again -> wr_err=1, count=32, entry 0 holds the new data.
- Consuming read of entry 9 (valid), then read 9 again -> first returns data and count drops 32->31; second gives rd_err=1, rd_valid=0, outputs unchanged.
- Same cycle: write entry 4 = {1,100,200}, with entry 4 previously {2,5,6}, and consuming read of entry 4 -> read data {2,5,6}, entry 4 = {1,100,200} valid, count unchanged, wr_err=0.
- DEPTH=20: write_pointer=25 -> wr_err=1, count unchanged; read_pointer=31 -> rd_err=1.
